// File: rtl/bit_population_counter_pipe_if.sv
// bit_population_counter_pipe_if: valid/ready stream bundle for the pipelined popcount.
//   in_data/in_zeros/in_val/in_ready    : upstream word, count mode, valid, ready
//   out_data/out_val/out_ready          : downstream count, valid, ready
//   master: the environment (source + sink); slave: the counter block
interface bit_population_counter_pipe_if #(
    parameter int WIDTH = 64
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] in_data;
    logic             in_zeros;
    logic             in_val;
    logic             in_ready;
    logic [CW-1:0]    out_data;
    logic             out_val;
    logic             out_ready;

    modport master (
        output in_data, in_zeros, in_val, out_ready,
        input  in_ready, out_data, out_val
    );

    modport slave (
        input  in_data, in_zeros, in_val, out_ready,
        output in_ready, out_data, out_val
    );
endinterface

// File: rtl/bit_population_counter_pipe.sv
// bit_population_counter_pipe: two-stage pipelined population count (ones or zeros).
//   clk_i   : clock, rising edge
//   arstn_i : asynchronous active-low reset; discards words in flight
//   bus     : slave side of the stream bundle
//             in_*  word + zeros-mode in, valid/ready handshake
//             out_* count of the accepted word, valid/ready handshake
//   Stage 1 registers per-slice counts of CHUNK-bit slices, stage 2 registers their sum.
module bit_population_counter_pipe #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input logic clk_i,
    input logic arstn_i,
    bit_population_counter_pipe_if.slave bus
);
    localparam int NCH = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int CW  = $clog2(WIDTH) + 1;
    localparam int SW  = $clog2(CHUNK) + 1;

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_params
        $error("bit_population_counter_pipe: illegal WIDTH=%0d CHUNK=%0d", WIDTH, CHUNK);
    end

    logic                 en1;
    logic                 en2;
    logic                 s1_val;
    logic [NCH*CHUNK-1:0] src;
    logic [SW-1:0]        slice_d [NCH];
    logic [SW-1:0]        slice   [NCH];
    logic [CW-1:0]        sum;

    // Stage 2 frees up when empty or draining; stage 1 when empty or stage 2 frees up.
    assign en2         = !bus.out_val || bus.out_ready;
    assign en1         = !s1_val || en2;
    assign bus.in_ready = en1;

    // Inversion happens before padding, so padding bits stay zero and never count.
    always_comb begin
        src = '0;
        src[WIDTH-1:0] = bus.in_zeros ? ~bus.in_data : bus.in_data;
        for (int k = 0; k < NCH; k++) begin
            slice_d[k] = '0;
            for (int b = 0; b < CHUNK; b++) slice_d[k] = slice_d[k] + SW'(src[k*CHUNK+b]);
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < NCH; k++) sum = sum + CW'(slice[k]);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            s1_val <= 1'b0;
            for (int k = 0; k < NCH; k++) slice[k] <= '0;
        end else if (en1) begin
            s1_val <= bus.in_val;
            if (bus.in_val) slice <= slice_d;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            bus.out_val  <= 1'b0;
            bus.out_data <= '0;
        end else if (en2) begin
            bus.out_val <= s1_val;
            if (s1_val) bus.out_data <= sum;
        end
    end
endmodule

// File: tb/tb_bit_population_counter_pipe.sv
// tb_bit_population_counter_pipe: self-checking bench for the pipelined popcount.
//   Main instance WIDTH=16/CHUNK=4, plus WIDTH=10/CHUNK=4 and WIDTH=1/CHUNK=1 instances.
module tb_bit_population_counter_pipe;
    typedef struct {
        logic [15:0] data;
        logic        zeros;
        int          exp;
    } vec_t;

    typedef struct {
        logic [9:0] d10;
        logic       z10;
        int         e10;
        logic       d1;
        logic       z1;
        int         e1;
    } small_t;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   exp_q[$];
    vec_t tbl[9];
    small_t stbl[4];
    logic [15:0] w3[4];
    int   idx;
    int   n;
    logic acc;

    always #5 clk = ~clk;

    bit_population_counter_pipe_if #(.WIDTH(16)) bus ();
    bit_population_counter_pipe_if #(.WIDTH(10)) b10 ();
    bit_population_counter_pipe_if #(.WIDTH(1))  b1 ();

    bit_population_counter_pipe #(.WIDTH(16), .CHUNK(4)) dut (.clk_i(clk), .arstn_i(arstn), .bus(bus));
    bit_population_counter_pipe #(.WIDTH(10), .CHUNK(4)) dut10 (.clk_i(clk), .arstn_i(arstn), .bus(b10));
    bit_population_counter_pipe #(.WIDTH(1), .CHUNK(1)) dut1 (.clk_i(clk), .arstn_i(arstn), .bus(b1));

    function automatic int ref_pop(logic [15:0] d, logic z);
        return $countones(z ? ~d : d);
    endfunction

    task automatic check(string name, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every accepted word must come out once, in order, with its reference count.
    always @(negedge clk) begin
        if (arstn) begin
            if (bus.out_val && bus.out_ready) begin
                if (exp_q.size() == 0) check("spurious output", 1, 0);
                else check("stream order/count", int'(bus.out_data), exp_q.pop_front());
            end
            if (bus.in_val && bus.in_ready) exp_q.push_back(ref_pop(bus.in_data, bus.in_zeros));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic drain();
        bus.in_val = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain empty", exp_q.size(), 0);
    endtask

    initial begin
        bus.in_val = 0; bus.in_data = '0; bus.in_zeros = 0; bus.out_ready = 1;
        b10.in_val = 0; b10.in_data = '0; b10.in_zeros = 0; b10.out_ready = 1;
        b1.in_val = 0; b1.in_data = '0; b1.in_zeros = 0; b1.out_ready = 1;
        tbl[0] = '{16'hFFFF, 1'b0, 16};
        tbl[1] = '{16'h0000, 1'b0, 0};
        tbl[2] = '{16'h0000, 1'b1, 16};
        tbl[3] = '{16'h00F0, 1'b1, 12};
        tbl[4] = '{16'h8001, 1'b0, 2};
        tbl[5] = '{16'hA5A5, 1'b0, 8};
        tbl[6] = '{16'hFFFF, 1'b1, 0};
        tbl[7] = '{16'h1234, 1'b0, 5};
        tbl[8] = '{16'h7FFE, 1'b1, 2};
        stbl[0] = '{10'h000, 1'b1, 10, 1'b1, 1'b0, 1};
        stbl[1] = '{10'h3FF, 1'b0, 10, 1'b0, 1'b0, 0};
        stbl[2] = '{10'h3FF, 1'b1, 0, 1'b0, 1'b1, 1};
        stbl[3] = '{10'h201, 1'b0, 2, 1'b1, 1'b1, 0};
        w3[0] = 16'h000F; w3[1] = 16'h00FF; w3[2] = 16'h0FFF; w3[3] = 16'hF0F0;

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", bus.in_ready, 1);
        check("reset out_val", bus.out_val, 0);
        check("reset out_data", int'(bus.out_data), 0);
        arstn = 1'b1;
        @(posedge clk); #1;

        // Single words: count, 2-cycle latency, 1-cycle valid pulse.
        foreach (tbl[i]) begin
            bus.in_val = 1; bus.in_data = tbl[i].data; bus.in_zeros = tbl[i].zeros;
            @(posedge clk); #1;
            bus.in_val = 0;
            n = 1;
            while (!bus.out_val && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            check("table latency", n, 2);
            check("table count", int'(bus.out_data), tbl[i].exp);
            @(posedge clk); #1;
            check("table pulse", bus.out_val, 0);
        end

        // Back-to-back words on consecutive cycles.
        bus.in_val = 1; bus.in_data = 16'h0000; bus.in_zeros = 0;
        @(posedge clk); #1;
        bus.in_data = 16'h00F0; bus.in_zeros = 1;
        @(posedge clk); #1;
        check("b2b val0", bus.out_val, 1);
        check("b2b data0", int'(bus.out_data), 0);
        bus.in_data = 16'h8001; bus.in_zeros = 0;
        @(posedge clk); #1;
        bus.in_val = 0;
        check("b2b val1", bus.out_val, 1);
        check("b2b data1", int'(bus.out_data), 12);
        @(posedge clk); #1;
        check("b2b val2", bus.out_val, 1);
        check("b2b data2", int'(bus.out_data), 2);
        drain();

        // Downstream stall with four words offered.
        bus.out_ready = 0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            bus.in_val = (idx < 4); bus.in_data = w3[idx % 4]; bus.in_zeros = 0;
            @(negedge clk);
            if (bus.in_val && bus.in_ready) idx++;
            @(posedge clk); #1;
            if (c >= 2) begin
                check("stall val held", bus.out_val, 1);
                check("stall data held", int'(bus.out_data), 4);
            end
        end
        check("stall accepted", idx, 2);
        check("stall in_ready low", bus.in_ready, 0);
        bus.out_ready = 1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            bus.in_val = 1; bus.in_data = w3[idx]; bus.in_zeros = 0;
            @(negedge clk);
            if (bus.in_ready) idx++;
            @(posedge clk); #1;
        end
        bus.in_val = 0;
        check("stall all sent", idx, 4);
        drain();

        // Randomised traffic against the scoreboard.
        acc = 0;
        for (int i = 0; i < 10000; i++) begin
            if (!bus.in_val || acc) begin
                bus.in_val = ($urandom_range(0, 3) != 0);
                bus.in_data = 16'($urandom);
                bus.in_zeros = 1'($urandom_range(0, 1));
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = bus.in_val && bus.in_ready;
            @(posedge clk); #1;
        end
        drain();

        // Asynchronous reset with two words in flight.
        bus.out_ready = 0;
        for (int c = 0; c < 2; c++) begin
            bus.in_val = 1; bus.in_data = (c == 0) ? 16'hFFFF : 16'h00FF; bus.in_zeros = 0;
            @(posedge clk); #1;
        end
        bus.in_val = 0;
        check("pre-reset full", bus.out_val, 1);
        #2;
        arstn = 0;
        #1;
        check("async out_val", bus.out_val, 0);
        check("async in_ready", bus.in_ready, 1);
        check("async out_data", int'(bus.out_data), 0);
        exp_q.delete();
        @(posedge clk); #2;
        arstn = 1;
        bus.out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("no stale output", bus.out_val, 0);
        end
        check("post-reset in_ready", bus.in_ready, 1);

        // Odd widths: padding excluded, single-bit word.
        foreach (stbl[i]) begin
            b10.in_val = 1; b10.in_data = stbl[i].d10; b10.in_zeros = stbl[i].z10;
            b1.in_val = 1; b1.in_data = stbl[i].d1; b1.in_zeros = stbl[i].z1;
            @(posedge clk); #1;
            b10.in_val = 0; b1.in_val = 0;
            @(posedge clk); #1;
            check("w10 val", b10.out_val, 1);
            check("w10 count", int'(b10.out_data), stbl[i].e10);
            check("w1 val", b1.out_val, 1);
            check("w1 count", int'(b1.out_data), stbl[i].e1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
